// File: rtl/ats_pkg.sv
// Shared definitions for the ATS frame/timestamp path.
// Holds the state encoding and the beat-count helper used by both the
// timestamp merger and the timestamp separator.
package ats_pkg;

    typedef enum logic [1:0] {
        PASS_FRAME      = 2'd0,
        WAIT_TIMESTAMP  = 2'd1,
        WRITE_TIMESTAMP = 2'd2,
        WRITE_LENGTH    = 2'd3
    } ats_state_t;

    // Number of DATA_WIDTH beats needed to carry a field of total_width bits
    function automatic int beat_num(input int total_width, input int data_width);
        return total_width / data_width;
    endfunction

endpackage

// File: rtl/merge_timestamp.sv
// Transmit-side timestamp merger for the ATS path.
// Emits [Ethernet frame][timestamp, LSB beat first] on m_axis and the frame
// beat count on m_axis_frame_length for the downstream separator.
// Optional build macro: MERGE_TIMESTAMP_TRUNCATE_EN (drops beats beyond the
// maximum frame size and saturates the reported length).
//
// state           | meaning
// ----------------+-----------------------------------------------------
// PASS_FRAME      | frame beats forwarded combinationally, length counted
// WAIT_TIMESTAMP  | frame done, timestamp for it not yet received
// WRITE_TIMESTAMP | serializing held timestamp, LSB beat first
// WRITE_LENGTH    | presenting frame length, input frame stream stalled
module merge_timestamp
    import ats_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int FRAME_LENGTH_WIDTH   = 16,
    parameter int ETHERNET_FRAME_WIDTH = 1600 * DATA_WIDTH,
    parameter int TIMESTAMP_WIDTH      = 72
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [TIMESTAMP_WIDTH-1:0]    s_axis_timestamp_tdata,
    input  logic                          s_axis_timestamp_tvalid,
    output logic                          s_axis_timestamp_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [FRAME_LENGTH_WIDTH-1:0] m_axis_frame_length_tdata,
    output logic                          m_axis_frame_length_tvalid,
    input  logic                          m_axis_frame_length_tready
);

    localparam int TIMESTAMP_BEAT_NUM      = beat_num(TIMESTAMP_WIDTH, DATA_WIDTH);
    localparam int ETHERNET_FRAME_BEAT_NUM = beat_num(ETHERNET_FRAME_WIDTH, DATA_WIDTH);
    localparam int TS_CNT_W = (TIMESTAMP_BEAT_NUM > 1) ? $clog2(TIMESTAMP_BEAT_NUM) : 1;
    localparam logic [TS_CNT_W-1:0] TS_LAST = TS_CNT_W'(TIMESTAMP_BEAT_NUM - 1);

    // Parameter sanity: all widths must be whole beats, max frame must fit the length field
    if ((FRAME_LENGTH_WIDTH % DATA_WIDTH) != 0)
        $error("FRAME_LENGTH_WIDTH must be a multiple of DATA_WIDTH");
    if ((ETHERNET_FRAME_WIDTH % DATA_WIDTH) != 0)
        $error("ETHERNET_FRAME_WIDTH must be a multiple of DATA_WIDTH");
    if ((TIMESTAMP_WIDTH % DATA_WIDTH) != 0)
        $error("TIMESTAMP_WIDTH must be a multiple of DATA_WIDTH");
    if (ETHERNET_FRAME_BEAT_NUM >= (64'd1 << FRAME_LENGTH_WIDTH))
        $error("maximum frame beat count does not fit FRAME_LENGTH_WIDTH");

    ats_state_t                    state;
    logic [FRAME_LENGTH_WIDTH-1:0] len_cnt;
    logic [FRAME_LENGTH_WIDTH-1:0] len_inc;
    logic [FRAME_LENGTH_WIDTH-1:0] frame_length;
    logic [TIMESTAMP_WIDTH-1:0]    ts_reg;
    logic                          ts_full;
    logic [TS_CNT_W-1:0]           ts_cnt;
    logic                          s_hs;
    logic                          ts_hs;

`ifdef MERGE_TIMESTAMP_TRUNCATE_EN
    localparam logic [FRAME_LENGTH_WIDTH-1:0] MAX_LEN = FRAME_LENGTH_WIDTH'(ETHERNET_FRAME_BEAT_NUM);
    logic len_sat;
    assign len_sat = (len_cnt == MAX_LEN);
    // Saturated count doubles as the reported length of a truncated frame
    assign len_inc = len_sat ? len_cnt : len_cnt + 1'b1;
`else
    assign len_inc = len_cnt + 1'b1;
`endif

    assign s_hs                      = s_axis_tvalid && s_axis_tready;
    assign ts_hs                     = s_axis_timestamp_tvalid && !ts_full;
    assign s_axis_timestamp_tready   = !ts_full;
    assign m_axis_frame_length_tdata = frame_length;

    // Output stream mux: zero-latency pass-through for frame beats, held timestamp otherwise
    always_comb begin
        s_axis_tready              = 1'b0;
        m_axis_tvalid              = 1'b0;
        m_axis_tdata               = '0;
        m_axis_tlast               = 1'b0;
        m_axis_frame_length_tvalid = 1'b0;
        case (state)
            PASS_FRAME: begin
                m_axis_tdata = s_axis_tdata;
`ifdef MERGE_TIMESTAMP_TRUNCATE_EN
                if (len_sat) begin
                    s_axis_tready = 1'b1;
                    m_axis_tvalid = 1'b0;
                end else begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                end
`else
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
`endif
            end
            WRITE_TIMESTAMP: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = ts_reg[DATA_WIDTH*int'(ts_cnt) +: DATA_WIDTH];
                m_axis_tlast  = (ts_cnt == TS_LAST);
            end
            WRITE_LENGTH: begin
                m_axis_frame_length_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer: counts frame beats, holds the timestamp, walks the output phases
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PASS_FRAME;
            len_cnt      <= '0;
            frame_length <= '0;
            ts_reg       <= '0;
            ts_full      <= 1'b0;
            ts_cnt       <= '0;
        end else begin
            // ts_full is never set while WRITE_TIMESTAMP clears it, so load and clear cannot collide
            if (ts_hs) begin
                ts_reg  <= s_axis_timestamp_tdata;
                ts_full <= 1'b1;
            end
            case (state)
                PASS_FRAME: begin
                    if (s_hs) begin
                        if (s_axis_tlast) begin
                            frame_length <= len_inc;
                            len_cnt      <= '0;
                            state        <= ts_full ? WRITE_TIMESTAMP : WAIT_TIMESTAMP;
                        end else begin
                            len_cnt <= len_inc;
                        end
                    end
                end
                WAIT_TIMESTAMP: begin
                    if (ts_full)
                        state <= WRITE_TIMESTAMP;
                end
                WRITE_TIMESTAMP: begin
                    if (m_axis_tready) begin
                        if (ts_cnt == TS_LAST) begin
                            ts_cnt  <= '0;
                            ts_full <= 1'b0;
                            state   <= WRITE_LENGTH;
                        end else begin
                            ts_cnt <= ts_cnt + 1'b1;
                        end
                    end
                end
                WRITE_LENGTH: begin
                    if (m_axis_frame_length_tready)
                        state <= PASS_FRAME;
                end
                default: begin
                    state        <= PASS_FRAME;
                    len_cnt      <= '0;
                    frame_length <= '0;
                    ts_reg       <= '0;
                    ts_full      <= 1'b0;
                    ts_cnt       <= '0;
                end
            endcase
        end
    end

endmodule
